// File: rtl/song_reader.sv
// song_reader: walks song ROM entries and turns them into per-voice note
// loads and beat-counted time advances for the 3-voice chord player.
module song_reader #(
  parameter int SONG_ADDR_W = 7,
  parameter int SONG_SEL_W  = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              play,
  input  logic [SONG_SEL_W-1:0]             song_sel,
  input  logic                              beat,
  output logic [SONG_SEL_W+SONG_ADDR_W-1:0] rom_addr,
  input  logic [14:0]                       rom_data,
  output logic [5:0]                        note_to_load1,
  output logic [5:0]                        note_to_load2,
  output logic [5:0]                        note_to_load3,
  output logic [5:0]                        duration_to_load1,
  output logic [5:0]                        duration_to_load2,
  output logic [5:0]                        duration_to_load3,
  output logic                              load_new_note1,
  output logic                              load_new_note2,
  output logic                              load_new_note3,
  output logic                              song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    LOAD,
    ADVANCE,
    DONE
  } state_t;

  localparam logic [SONG_ADDR_W-1:0] LAST_IDX = '1;

  state_t                  state_reg;
  logic [SONG_ADDR_W-1:0]  entry_idx_reg;
  logic [5:0]              beat_cnt_reg;
  logic [SONG_SEL_W-1:0]   sel_reg;
  // Set when an advance entry sat at the last index: the index cannot move
  // past it, so this remembers that the song ends once the wait is over.
  logic                    last_reg;
  logic [1:0]              voice_reg;
  logic [5:0]              note_reg [3];
  logic [5:0]              dur_reg  [3];
  logic                    load_vec [3];

  // ROM word fields
  logic       word_adv;
  logic [1:0] word_voice;
  logic [5:0] word_note;
  logic [5:0] word_dur;
  logic       word_end;
  logic       sel_change;
  logic       at_last;

  assign word_adv   = rom_data[14];
  assign word_voice = rom_data[13:12];
  assign word_note  = rom_data[11:6];
  assign word_dur   = rom_data[5:0];
  assign word_end   = (rom_data == 15'h0000);
  assign sel_change = (song_sel != sel_reg);
  assign at_last    = (entry_idx_reg == LAST_IDX);

  // The address is always the current entry of the registered song; in DONE
  // the index is simply never moved again, so the address stays put.
  assign rom_addr  = {sel_reg, entry_idx_reg};
  assign song_done = (state_reg == DONE);

  // Sequencer: reset, then song change, then pause, then normal stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      entry_idx_reg <= '0;
      beat_cnt_reg  <= '0;
      sel_reg       <= song_sel;
      last_reg      <= 1'b0;
      voice_reg     <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        note_reg[i] <= '0;
        dur_reg[i]  <= '0;
      end
    end else if (sel_change) begin
      sel_reg       <= song_sel;
      entry_idx_reg <= '0;
      beat_cnt_reg  <= '0;
      last_reg      <= 1'b0;
      state_reg     <= play ? FETCH : IDLE;
    end else if (play) begin
      case (state_reg)
        IDLE:   state_reg <= FETCH;
        FETCH:  state_reg <= DECODE;
        DECODE: begin
          if (word_end) begin
            state_reg <= DONE;
          end else if (word_adv) begin
            beat_cnt_reg <= word_dur;
            state_reg    <= ADVANCE;
            if (at_last) last_reg <= 1'b1;
            else         entry_idx_reg <= entry_idx_reg + 1'b1;
          end else if (word_voice != 2'd0) begin
            voice_reg                   <= word_voice;
            note_reg[word_voice - 2'd1] <= word_note;
            dur_reg[word_voice - 2'd1]  <= word_dur;
            state_reg                   <= LOAD;
          end else if (at_last) begin
            state_reg <= DONE;
          end else begin
            entry_idx_reg <= entry_idx_reg + 1'b1;
            state_reg     <= FETCH;
          end
        end
        LOAD: begin
          if (at_last) begin
            state_reg <= DONE;
          end else begin
            entry_idx_reg <= entry_idx_reg + 1'b1;
            state_reg     <= FETCH;
          end
        end
        ADVANCE: begin
          if (beat_cnt_reg == 6'd0) state_reg <= last_reg ? DONE : FETCH;
          else if (beat)            beat_cnt_reg <= beat_cnt_reg - 6'd1;
        end
        DONE:    state_reg <= DONE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Load strobes follow the LOAD state but are masked in the very cycle a
  // pause, song change or reset takes effect, so a frozen or abandoned LOAD
  // never fires early.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_voice
      localparam logic [1:0] VID = 2'(gi + 1);
      assign load_vec[gi] = (state_reg == LOAD) && (voice_reg == VID) &&
                            play && !reset && !sel_change;
    end
  endgenerate

  assign load_new_note1    = load_vec[0];
  assign load_new_note2    = load_vec[1];
  assign load_new_note3    = load_vec[2];
  assign note_to_load1     = note_reg[0];
  assign note_to_load2     = note_reg[1];
  assign note_to_load3     = note_reg[2];
  assign duration_to_load1 = dur_reg[0];
  assign duration_to_load2 = dur_reg[1];
  assign duration_to_load3 = dur_reg[2];

endmodule
